// File: rtl/rr_arbiter_4_v_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 4-way round-robin arbiter.
// Pure declarations; no latency and no backpressure.
// Imported by the arbiter top and its priority encoder.
package rr_arbiter_4_v_pkg;

  localparam int N_REQ  = 4;
  localparam int CODE_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] to_onehot(input logic [CODE_W-1:0] code);
    to_onehot       = '0;
    to_onehot[code] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_v_enc.sv
// 4:2 priority encoder; the highest set input bit wins.
// Purely combinational, zero latency.
// No backpressure; o_valid is low when no input bit is set.
module priority_enc_4_2_v
  import rr_arbiter_4_v_pkg::*;
(
  input  logic [N_REQ-1:0]  i_code,
  output logic [CODE_W-1:0] o_code,
  output logic              o_valid
);

  always_comb begin
    o_code = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i_code[i]) o_code = CODE_W'(i);
    end
  end

  assign o_valid = |i_code;

endmodule

// File: rtl/rr_arbiter_4_v.sv
// Four-requester round-robin arbiter with grant hold until done, withdrawal or hold timeout.
// Grant visible one cycle after a request is sampled in IDLE; release clears outputs at the next edge.
// Requesters hold i_req until served; at least one idle cycle separates consecutive grants.
module rr_arbiter_4_v
  import rr_arbiter_4_v_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_REQ-1:0]  i_req,
  input  logic              i_done,
  output logic [N_REQ-1:0]  o_gnt,
  output logic [CODE_W-1:0] o_gnt_code,
  output logic              o_gnt_valid,
  output logic              o_timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t              state;
  logic [CODE_W-1:0]   ptr;
  logic [CNT_W-1:0]    cnt;
  logic [N_REQ-1:0]    rot_req;
  logic [CODE_W-1:0]   src;
  logic [CODE_W-1:0]   enc_code;
  logic                enc_valid;
  logic [CODE_W-1:0]   win;
  logic                withdraw;
  logic                hold_hit;
  logic                release_now;

  // Rotate so requester ptr lands on bit 3, ptr-1 on bit 2, and so on.
  always_comb begin
    rot_req = '0;
    src     = '0;
    for (int j = 0; j < N_REQ; j++) begin
      src        = ptr + CODE_W'(j) + CODE_W'(1);
      rot_req[j] = i_req[src];
    end
  end

  priority_enc_4_2_v u_enc (
    .i_code  (rot_req),
    .o_code  (enc_code),
    .o_valid (enc_valid)
  );

  assign win         = enc_code + ptr + CODE_W'(1);
  assign withdraw    = ~i_req[o_gnt_code];
  assign hold_hit    = (HOLD_MAX != 0) && (cnt == HOLD_LAST);
  assign release_now = i_done || withdraw || hold_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      ptr         <= CODE_W'(3);
      cnt         <= '0;
      o_gnt       <= '0;
      o_gnt_code  <= '0;
      o_gnt_valid <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enc_valid) begin
            state       <= ST_GRANT;
            cnt         <= '0;
            o_gnt       <= to_onehot(win);
            o_gnt_code  <= win;
            o_gnt_valid <= 1'b1;
          end
        end
        ST_GRANT: begin
          cnt <= cnt + CNT_W'(1);
          if (release_now) begin
            state       <= ST_IDLE;
            ptr         <= o_gnt_code - CODE_W'(1);
            o_gnt       <= '0;
            o_gnt_code  <= '0;
            o_gnt_valid <= 1'b0;
            // Timeout pulse only when the counter alone forced the release.
            o_timeout   <= hold_hit && !i_done && !withdraw;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4_v.sv
// Scoreboard bench for rr_arbiter_4_v with HOLD_MAX=4: directed steps push expected outputs,
// a monitor pops and compares one entry per clock.
module tb_rr_arbiter_4_v;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_code;
  logic       gnt_valid;
  logic       timeout;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int step_no  = 0;

  logic [7:0] sb[$];

  rr_arbiter_4_v #(.HOLD_MAX(4), .CNT_W(3)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_done      (done),
    .o_gnt       (gnt),
    .o_gnt_code  (gnt_code),
    .o_gnt_valid (gnt_valid),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pack(input logic [3:0] g, input logic [1:0] c, input logic v,
                                      input logic t);
    return {g, c, v, t};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got gnt=%b code=%b vld=%b to=%b, want gnt=%b code=%b vld=%b to=%b",
                  name, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
  endtask

  // Drive inputs for the next edge and queue the outputs expected after it.
  task automatic step(input logic [3:0] r, input logic d, input logic [3:0] g,
                      input logic [1:0] c, input logic t);
    @(negedge clk);
    req  = r;
    done = d;
    sb.push_back(pack(g, c, |g, t));
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      logic [7:0] exp;
      exp = sb.pop_front();
      step_no++;
      check($sformatf("step%0d", step_no), pack(gnt, gnt_code, gnt_valid, timeout), exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #3;
    check("reset_state", pack(gnt, gnt_code, gnt_valid, timeout), 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all requesting, done on 2nd grant cycle; order 3,2,1,0,3.
    step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0);
    step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0);
    step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0);
    step(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0);
    step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b0);
    step(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b0);
    step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0);
    step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0);
    step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0);
    step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0);
    step(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0);

    // Timeout: requester 0 held for exactly 4 cycles, pulse as grant drops.
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
    step(4'b0001, 1'b0, 4'b0000, 2'd0, 1'b1);
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);

    // Done on the 4th grant cycle: normal release, no timeout pulse.
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
    step(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // Withdrawal: grant 1 ignores other lines, drops when req[1] falls; 0 wins next.
    step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
    step(4'b1011, 1'b0, 4'b0010, 2'd1, 1'b0);
    step(4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0);
    step(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b0);
    step(4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // Single request, done release, then done while idle changes nothing.
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
    step(4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);

    // Asynchronous reset mid-grant on requester 2, between edges.
    @(negedge clk);
    check("pre_reset_grant", pack(gnt, gnt_code, gnt_valid, timeout), pack(4'b0100, 2'd2, 1'b1, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", pack(gnt, gnt_code, gnt_valid, timeout), 8'h00);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Pointer back at 3 after reset.
    step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0);
    step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    chk_cnt++;
    if (sb.size() == 0) pass_cnt++;
    else $display("FAIL drain: %0d expected entries left, want 0", sb.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
